// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and 16x oversampling constants.
// Used by uart_recv and uart_send.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int SAMPLE_MID = 7;
   localparam int SAMPLE_END = 15;

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(SAMPLE_MID);
   localparam logic [TICK_W-1:0] TICK_END = TICK_W'(SAMPLE_END);

endpackage

// File: rtl/uart_recv_sync_fifo.sv
// First-word-fall-through FIFO; push/pop take effect on the clock edge and dout follows the head pointer.
// A push into a full FIFO is dropped and flagged on ovf_pulse unless a pop frees the slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int CNT_W = AW + 1
) (
   input  logic             clk_uart16,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count,
   output logic             ovf_pulse
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             do_push;
   logic             do_pop;

   assign empty     = (count_q == '0);
   assign full      = (count_q == FULL_CNT);
   assign count     = count_q;
   assign do_pop    = pop && !empty;
   // A pop on the same edge frees the slot, so a full FIFO can still accept
   assign do_push   = push && (!full || do_pop);
   assign ovf_pulse = push && full && !pop;
   assign dout      = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_uart16 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_uart16) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver at 16x oversampling feeding a FWFT FIFO; a byte is visible 153 cycles after the start edge is seen.
// No backpressure on the line: bytes arriving into a full FIFO are dropped and reported via the sticky overflow flag.
module uart_recv
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_uart16,
   input  logic             rst_n,
   input  logic             rx,
   input  logic             pop,
   input  logic             clr_err,
   output logic [7:0]       data,
   output logic             valid,
   output logic [CNT_W-1:0] count,
   output logic             frame_err,
   output logic             overflow
);

   logic              rx_meta_q;
   logic              rx_s_q;
   rx_state_t         state_q;
   logic [TICK_W-1:0] tick_q;
   logic [2:0]        bit_q;
   logic [7:0]        shift_q;
   logic              frame_err_q;
   logic              frame_err_d;
   logic              overflow_q;
   logic              overflow_d;
   logic              stop_sample;
   logic              byte_ok;
   logic              stop_bad;
   logic              fifo_empty;
   logic              fifo_full;
   logic              ovf_pulse;

   always_ff @(posedge clk_uart16 or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk_uart16 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!rx_s_q) begin
                  state_q <= START;
                  tick_q  <= '0;
               end
            end
            START: begin
               if (tick_q == TICK_MID) begin
                  tick_q <= '0;
                  if (rx_s_q) begin
                     state_q <= IDLE;
                  end else begin
                     state_q <= DATA;
                     bit_q   <= '0;
                  end
               end else begin
                  tick_q <= tick_q + TICK_W'(1);
               end
            end
            DATA: begin
               // tick wraps 15 -> 0 on its own between bits
               tick_q <= tick_q + TICK_W'(1);
               if (tick_q == TICK_END) begin
                  shift_q <= {rx_s_q, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_q <= STOP;
                     tick_q  <= '0;
                  end
               end
            end
            STOP: begin
               tick_q <= tick_q + TICK_W'(1);
               if (tick_q == TICK_END) begin
                  state_q <= IDLE;
                  tick_q  <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
               tick_q  <= '0;
            end
         endcase
      end
   end

   assign stop_sample = (state_q == STOP) && (tick_q == TICK_END);
   assign byte_ok     = stop_sample && rx_s_q;
   assign stop_bad    = stop_sample && !rx_s_q;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_uart16 (clk_uart16),
      .rst_n      (rst_n),
      .push       (byte_ok),
      .pop        (pop),
      .din        (shift_q),
      .dout       (data),
      .empty      (fifo_empty),
      .full       (fifo_full),
      .count      (count),
      .ovf_pulse  (ovf_pulse)
   );

   // A new error in the same cycle as clr_err keeps the flag set
   assign frame_err_d = stop_bad || (frame_err_q && !clr_err);
   assign overflow_d  = (ovf_pulse && fifo_full) || (overflow_q && !clr_err);

   always_ff @(posedge clk_uart16 or negedge rst_n) begin
      if (!rst_n) begin
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   assign valid     = !fifo_empty;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;

endmodule
